// File: rtl/bus_mux_pipe.sv
// Priority bus multiplexer with registered output pipeline, hold-last-value,
// sticky conflict flag and winner index. Optional counter: BUS_MUX_CONFLICT_CNT_EN.
module bus_mux_pipe #(
   parameter int unsigned NUM_SRC     = 24,
   parameter int unsigned DATA_W      = 32,
   parameter int unsigned PIPE_STAGES = 1,
   localparam int unsigned IDX_W      = (NUM_SRC > 2) ? $clog2(NUM_SRC) : 1
) (
   input  logic                        clk,
   input  logic                        clr,
   input  logic [NUM_SRC*DATA_W-1:0]   src_data,
   input  logic [NUM_SRC-1:0]          src_out,
   input  logic                        hold_en,
   input  logic                        conflict_clr,
   output logic [DATA_W-1:0]           bus_out,
   output logic                        bus_valid,
   output logic [IDX_W-1:0]            bus_idx,
   output logic                        conflict,
   output logic [15:0]                 conflict_cnt
);

   logic [IDX_W-1:0]  win_idx;
   logic [DATA_W-1:0] win_data;
   logic              any;
   logic              multi;

   logic [DATA_W-1:0] hold_q, hold_d;
   logic [DATA_W-1:0] s1_data_q, s1_data_d;
   logic              s1_valid_q, s1_valid_d;
   logic [IDX_W-1:0]  s1_idx_q, s1_idx_d;
   logic              conflict_q, conflict_d;

   // Highest asserted enable wins: later loop iterations override earlier ones.
   always_comb begin
      win_idx  = '0;
      win_data = '0;
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
         if (src_out[i]) begin
            win_idx  = IDX_W'(i);
            win_data = src_data[i*DATA_W +: DATA_W];
         end
      end
   end

   assign any   = |src_out;
   assign multi = ($countones(src_out) > 1);

   always_comb begin
      hold_d     = hold_q;
      s1_data_d  = '0;
      s1_valid_d = any;
      s1_idx_d   = '0;
      if (any) begin
         hold_d    = win_data;
         s1_data_d = win_data;
         s1_idx_d  = win_idx;
      end else if (hold_en) begin
         s1_data_d = hold_q;
      end
      // Set has priority over the synchronous clear.
      conflict_d = multi | (conflict_q & ~conflict_clr);
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         hold_q     <= '0;
         s1_data_q  <= '0;
         s1_valid_q <= 1'b0;
         s1_idx_q   <= '0;
         conflict_q <= 1'b0;
      end else begin
         hold_q     <= hold_d;
         s1_data_q  <= s1_data_d;
         s1_valid_q <= s1_valid_d;
         s1_idx_q   <= s1_idx_d;
         conflict_q <= conflict_d;
      end
   end

   assign conflict = conflict_q;

   generate
      if (PIPE_STAGES == 2) begin : g_stage2
         logic [DATA_W-1:0] s2_data_q, s2_data_d;
         logic              s2_valid_q, s2_valid_d;
         logic [IDX_W-1:0]  s2_idx_q, s2_idx_d;

         always_comb begin
            s2_data_d  = s1_data_q;
            s2_valid_d = s1_valid_q;
            s2_idx_d   = s1_idx_q;
         end

         always_ff @(posedge clk or posedge clr) begin
            if (clr) begin
               s2_data_q  <= '0;
               s2_valid_q <= 1'b0;
               s2_idx_q   <= '0;
            end else begin
               s2_data_q  <= s2_data_d;
               s2_valid_q <= s2_valid_d;
               s2_idx_q   <= s2_idx_d;
            end
         end

         assign bus_out   = s2_data_q;
         assign bus_valid = s2_valid_q;
         assign bus_idx   = s2_idx_q;
      end else begin : g_stage1
         assign bus_out   = s1_data_q;
         assign bus_valid = s1_valid_q;
         assign bus_idx   = s1_idx_q;
      end
   endgenerate

`ifdef BUS_MUX_CONFLICT_CNT_EN
   logic [15:0] cnt_q, cnt_d;

   // Saturating event counter; an increment beats a same-cycle clear.
   always_comb begin
      cnt_d = cnt_q;
      if (multi) begin
         if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
      end else if (conflict_clr) begin
         cnt_d = 16'h0000;
      end
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) cnt_q <= 16'h0000;
      else     cnt_q <= cnt_d;
   end

   assign conflict_cnt = cnt_q;
`else
   assign conflict_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_bus_mux_pipe.sv
// Scoreboard bench for bus_mux_pipe: one-stage and two-stage instances driven
// in parallel, checked against a behavioural model of the selection rules.
module tb_bus_mux_pipe;
   localparam int NS = 24;
   localparam int DW = 32;

   typedef struct packed {
      logic [31:0] d;
      logic        v;
      logic [4:0]  idx;
   } exp_t;

   typedef struct packed {
      logic        cf;
      logic [15:0] cnt;
   } cf_t;

   logic              clk = 1'b0;
   logic              clr = 1'b1;
   logic [NS*DW-1:0]  src_data = '0;
   logic [NS-1:0]     src_out = '0;
   logic              hold_en = 1'b0;
   logic              conflict_clr = 1'b0;

   logic [31:0] bus1, bus2;
   logic        val1, val2;
   logic [4:0]  idx1, idx2;
   logic        cf1, cf2;
   logic [15:0] cnt1, cnt2;

   bus_mux_pipe #(.NUM_SRC(NS), .DATA_W(DW), .PIPE_STAGES(1)) dut1 (
      .clk(clk), .clr(clr), .src_data(src_data), .src_out(src_out),
      .hold_en(hold_en), .conflict_clr(conflict_clr),
      .bus_out(bus1), .bus_valid(val1), .bus_idx(idx1),
      .conflict(cf1), .conflict_cnt(cnt1));

   bus_mux_pipe #(.NUM_SRC(NS), .DATA_W(DW), .PIPE_STAGES(2)) dut2 (
      .clk(clk), .clr(clr), .src_data(src_data), .src_out(src_out),
      .hold_en(hold_en), .conflict_clr(conflict_clr),
      .bus_out(bus2), .bus_valid(val2), .bus_idx(idx2),
      .conflict(cf2), .conflict_cnt(cnt2));

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   bit mon_en = 1'b0;

   exp_t q1[$];
   exp_t q2[$];
   cf_t  qc[$];

   logic [31:0] word [NS];
   logic [31:0] hold_m = '0;
   logic        cf_m = 1'b0;
   int          cnt_i = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
      end
   endtask

   // Monitor: one output word per cycle on each instance.
   always @(negedge clk) begin
      if (mon_en) begin
         if (q1.size() == 0 || q2.size() == 0 || qc.size() == 0) begin
            total++;
            bad++;
            $display("FAIL queue_empty actual=%0d/%0d/%0d expected=nonzero", q1.size(), q2.size(), qc.size());
         end else begin
            exp_t e1, e2;
            cf_t  c;
            e1 = q1.pop_front();
            e2 = q2.pop_front();
            c  = qc.pop_front();
            chk("bus_out_p1",   bus1, e1.d);
            chk("bus_valid_p1", 32'(val1), 32'(e1.v));
            chk("bus_idx_p1",   32'(idx1), 32'(e1.idx));
            chk("bus_out_p2",   bus2, e2.d);
            chk("bus_valid_p2", 32'(val2), 32'(e2.v));
            chk("bus_idx_p2",   32'(idx2), 32'(e2.idx));
            chk("conflict_p1",  32'(cf1), 32'(c.cf));
            chk("conflict_p2",  32'(cf2), 32'(c.cf));
            chk("cnt_p1",       32'(cnt1), 32'(c.cnt));
            chk("cnt_p2",       32'(cnt2), 32'(c.cnt));
         end
      end
   end

   task automatic rand_words();
      for (int i = 0; i < NS; i++) word[i] = $urandom();
   endtask

   // Apply one cycle of stimulus and push what the bus must show for it.
   task automatic drive(input logic [NS-1:0] so, input logic he, input logic cc);
      exp_t e;
      cf_t  c;
      int   n;
      int   w;
      for (int i = 0; i < NS; i++) src_data[i*DW +: DW] = word[i];
      src_out      = so;
      hold_en      = he;
      conflict_clr = cc;
      n = 0;
      w = -1;
      for (int i = NS - 1; i >= 0; i--) begin
         if (so[i]) begin
            n++;
            if (w < 0) w = i;
         end
      end
      if (n > 0) begin
         e.d    = word[w];
         e.v    = 1'b1;
         e.idx  = 5'(w);
         hold_m = word[w];
      end else begin
         e.d   = he ? hold_m : 32'h0;
         e.v   = 1'b0;
         e.idx = 5'd0;
      end
      cf_m = (n >= 2) | (cf_m & ~cc);
`ifdef BUS_MUX_CONFLICT_CNT_EN
      if (n >= 2) cnt_i = cnt_i + 1;
      else if (cc) cnt_i = 0;
      c.cnt = (cnt_i > 65535) ? 16'hFFFF : 16'(cnt_i);
`else
      c.cnt = 16'h0000;
`endif
      c.cf = cf_m;
      q1.push_back(e);
      q2.push_back(e);
      qc.push_back(c);
      @(posedge clk);
      #1;
   endtask

   // Asynchronous reset: outputs must clear without waiting for an edge.
   task automatic reset_mid(input logic [NS-1:0] so);
      mon_en  = 1'b0;
      clr     = 1'b1;
      src_out = so;
      #1;
      chk("rst_bus_p1", bus1, 32'h0);
      chk("rst_bus_p2", bus2, 32'h0);
      chk("rst_valid",  32'({val1, val2}), 32'h0);
      chk("rst_idx",    32'({idx1, idx2}), 32'h0);
      chk("rst_conflict", 32'({cf1, cf2}), 32'h0);
      chk("rst_cnt",    32'({cnt1, cnt2}), 32'h0);
      @(posedge clk);
      #1;
      clr = 1'b0;
      q1.delete();
      q2.delete();
      qc.delete();
      q1.push_back('0);
      q2.push_back('0);
      q2.push_back('0);
      qc.push_back('0);
      hold_m = '0;
      cf_m   = 1'b0;
      cnt_i  = 0;
      mon_en = 1'b1;
   endtask

   initial begin
      #3000000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [NS-1:0] so;
      rand_words();
      @(posedge clk);
      #1;
      reset_mid('0);

      // Reset mid-stream with source 4 enabled.
      drive(24'h000010, 1'b0, 1'b0);
      drive(24'h000010, 1'b0, 1'b0);
      reset_mid(24'h000010);
      drive(24'h000010, 1'b0, 1'b0);

      // Single driver: PC at index 21.
      word[21] = 32'h0000_0040;
      drive(24'h1 << 21, 1'b0, 1'b0);
      drive(24'h0, 1'b0, 1'b0);

      // Priority between R3 and MDR, conflict stays sticky afterwards.
      word[3]  = 32'h1111_1111;
      word[22] = 32'hDEAD_BEEF;
      drive((24'h1 << 22) | (24'h1 << 3), 1'b0, 1'b0);
      drive(24'h0, 1'b1, 1'b0);
      drive(24'h0, 1'b1, 1'b0);

      // Hold last value, then drop to zero.
      word[5] = 32'hA5A5_0005;
      drive(24'h1 << 5, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) drive(24'h0, 1'b1, 1'b0);
      drive(24'h1 << 5, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) drive(24'h0, 1'b0, 1'b0);

      // Clear collides with set, then clear alone.
      drive(24'h000003, 1'b0, 1'b1);
      drive(24'h0, 1'b0, 1'b1);
      drive(24'h0, 1'b0, 1'b0);

      // Five conflict cycles counted from zero.
      drive(24'h0, 1'b0, 1'b1);
      for (int i = 0; i < 5; i++) drive(24'h800001, 1'b0, 1'b0);
      drive(24'h0, 1'b0, 1'b0);

      // Randomised traffic with a reset in the middle.
      for (int it = 0; it < 400; it++) begin
         rand_words();
         case ($urandom_range(0, 3))
            0: so = '0;
            1: so = 24'h1 << $urandom_range(0, NS - 1);
            2: so = (24'h1 << $urandom_range(0, NS - 1)) | (24'h1 << $urandom_range(0, NS - 1));
            default: so = 24'($urandom());
         endcase
         if (it == 200) reset_mid(so);
         drive(so, 1'($urandom_range(0, 1)), ($urandom_range(0, 9) == 0));
      end

`ifdef BUS_MUX_CONFLICT_CNT_EN
      // Drive the counter past saturation, then clear it.
      for (int i = 0; i < 65540; i++) drive(24'h000011, 1'b0, 1'b0);
      drive(24'h000011, 1'b0, 1'b1);
      drive(24'h0, 1'b0, 1'b1);
      drive(24'h0, 1'b0, 1'b0);
`endif

      drive(24'h0, 1'b0, 1'b0);
      drive(24'h0, 1'b0, 1'b0);
      mon_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
